noc_flit_depacketizer: RTL and testbench
========================================

# noc_flit_depacketizer

Receive-side network interface for one mesh node. It accepts flits from the router's local output port and validates the head flit's markers and destination. It latches the header fields, streams the data flits to the local AXI-side logic with a last flag, and consumes the tail flit. Malformed or misrouted packets are dropped and an error pulse is raised.

## Interface
Parameters:
- MY_X, 0: this node's X coordinate, width Noc_ID_X_Width.
- MY_Y, 0: this node's Y coordinate, width Noc_ID_Y_Width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  flit valid from the router local port.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- in_flit  in  Noc_Data_Width  flit.
- out_valid  out  1  data beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  Noc_Data_Width  data flit, unmodified.
- out_last  out  1  final data beat of the packet.
- hdr_valid  out  1  header fields below are valid, from the cycle after head accept until the tail is accepted.
- hdr_src_x / hdr_src_y  out  Noc_ID_X_Width / Noc_ID_Y_Width  source node.
- hdr_type  out  Axi_TYPE_Bit  AXI transaction type.
- hdr_order  out  Axi_PACK_ORDER_Bit  packet order number.
- hdr_len  out  Axi_LEN_Bit  AXI len; the packet carries len+1 data flits.
- hdr_user  out  Less_Byte  spare head bits [Noc_Point_E-1:0].
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = bad head marker, 2 = destination mismatch, 3 = bad tail; held until the next error.

## Operation
Head flit layout, MSB first:
- Noc_Head_H in [127:124].
- Source X then Y in [123:120].
- Dest X then Y in [119:116].
- Type in [115:113].
- Order in [112:105].
- Len in [104:97].
- Noc_Head_E in [96:93].
- User in [92:0].

Tail flit: Noc_Tail_H in [127:124] and Noc_Tail_E in [3:0]; the middle bits are ignored. Data flits are opaque.

Packet sequence: head, then len+1 data flits, then tail.

States:
- IDLE
  - in_ready=1.
  - Head with both markers correct and dest==(MY_X,MY_Y): latch fields, load beat counter with hdr_len, go to DATA.
  - Markers correct, dest mismatch: err code 2, go to DROP.
  - Marker wrong: err code 1, discard the flit, stay in IDLE.
- DATA
  - in_ready = !out_valid || out_ready.
  - Each accepted flit loads the output register.
  - out_last is set when the counter is 0; that flit moves the FSM to TAIL. Otherwise the counter decrements.
- TAIL
  - in_ready = 1, independent of the output stage.
  - Valid tail: hdr_valid is deasserted the next cycle, go to IDLE.
  - Anything else: err code 3, discard the flit, go to DROP.
- DROP
  - in_ready=1. Discard flits until a flit matching the tail markers is accepted, then go to IDLE.
  - No err pulse for flits discarded here.

Output register rules:
- out_valid/out_data/out_last are held stable while out_valid && !out_ready.
- A beat pending in the output register does not block TAIL or IDLE acceptance. The next head may be accepted while the final beat is still waiting.
- In that overlap case, hdr_* update on the new head. Consumers must sample hdr_* no later than the first beat of the packet.

Counter arithmetic:
- Width Axi_LEN_Bit; no wrap is possible. len=255 gives 256 data flits, counter 255 down to 0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, hdr_valid=0, all hdr_*=0, err_valid=0, err_code=0, state=IDLE, counter=0.
- in_ready rises the first cycle after reset release.
- Latency: data flit accepted at edge N appears on out_* at N+1; hdr_* and hdr_valid update at head-accept edge +1; err_valid pulses the cycle after the offending accept.
- Throughput: one flit per cycle when out_ready is held high.
- in_ready in DATA is a combinational function of out_ready; no other combinational in-to-out paths.
- Asynchronous reset mid-packet: the partial packet is abandoned, outputs clear immediately, no error is flagged. The router's remaining flits will hit IDLE and raise code 1 per flit; this is accepted behaviour.

## Structure
- Add to Noc_parameters:
  - Packed struct noc_head_flit_t, matching the head layout above.
  - Enum noc_depkt_state_t {IDLE, DATA, TAIL, DROP}.
  - Localparams for the error codes.
- Sub-module noc_pipe_reg: a one-entry valid/ready output register, WIDTH parameter, holds payload while stalled. It carries out_data plus out_last.

## Test plan
- Head src(2,1) dest(MY) type 3 order 5 len 3, four data flits, tail, out_ready=1 → four beats at one per cycle, out_last on the 4th, hdr_len=3, hdr_src=(2,1), no error.
- Same packet with out_ready toggling 1,0,0,1 → data held stable during stalls, no beat lost or duplicated, in_ready low whenever the register is full and out_ready=0.
- Head with dest (1,1) ≠ MY (0,0), 2 data flits, tail → err_code 2 pulse once, zero output beats, next valid packet passes normally.
- Head top nibble 4'hB → err_code 1, flit dropped, stays in IDLE.
- len=1 but three data flits before the tail → two beats out, err_code 3 on the third data flit, DROP swallows up to the tail, FSM returns to IDLE.
- Assert rst_n mid-DATA → all outputs 0 asynchronously; after release a fresh packet decodes correctly.

Source files
------------

// File: rtl/noc_flit_depacketizer_pkg.sv
// rtl/noc_flit_depacketizer_pkg.sv - NoC flit widths, marker values, head flit layout and depacketizer types
package noc_flit_depacketizer_pkg;

    localparam int Noc_Data_Width     = 128;
    localparam int Noc_ID_X_Width     = 2;
    localparam int Noc_ID_Y_Width     = 2;
    localparam int Axi_TYPE_Bit       = 3;
    localparam int Axi_PACK_ORDER_Bit = 8;
    localparam int Axi_LEN_Bit        = 8;
    localparam int Noc_Point_E        = 93;
    localparam int Less_Byte          = Noc_Point_E;

    localparam logic [3:0] Noc_Head_H = 4'hA;
    localparam logic [3:0] Noc_Head_E = 4'h5;
    localparam logic [3:0] Noc_Tail_H = 4'hC;
    localparam logic [3:0] Noc_Tail_E = 4'h3;

    localparam logic [1:0] ERR_HEAD = 2'd1;
    localparam logic [1:0] ERR_DEST = 2'd2;
    localparam logic [1:0] ERR_TAIL = 2'd3;

    typedef struct packed {
        logic [3:0]                    head_h;
        logic [Noc_ID_X_Width-1:0]     src_x;
        logic [Noc_ID_Y_Width-1:0]     src_y;
        logic [Noc_ID_X_Width-1:0]     dst_x;
        logic [Noc_ID_Y_Width-1:0]     dst_y;
        logic [Axi_TYPE_Bit-1:0]       typ;
        logic [Axi_PACK_ORDER_Bit-1:0] order;
        logic [Axi_LEN_Bit-1:0]        len;
        logic [3:0]                    head_e;
        logic [Less_Byte-1:0]          user;
    } noc_head_flit_t;

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DROP} noc_depkt_state_t;

endpackage

// File: rtl/noc_pipe_reg.sv
// rtl/noc_pipe_reg.sv - one-entry valid/ready register that holds its payload while stalled
module noc_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_flit_depacketizer.sv
// rtl/noc_flit_depacketizer.sv - validates head flits, streams data flits with last, consumes tails, drops bad packets
module noc_flit_depacketizer
    import noc_flit_depacketizer_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] MY_X = '0,
    parameter logic [Noc_ID_Y_Width-1:0] MY_Y = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [Noc_Data_Width-1:0]     in_flit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Noc_Data_Width-1:0]     out_data,
    output logic                          out_last,
    output logic                          hdr_valid,
    output logic [Noc_ID_X_Width-1:0]     hdr_src_x,
    output logic [Noc_ID_Y_Width-1:0]     hdr_src_y,
    output logic [Axi_TYPE_Bit-1:0]       hdr_type,
    output logic [Axi_PACK_ORDER_Bit-1:0] hdr_order,
    output logic [Axi_LEN_Bit-1:0]        hdr_len,
    output logic [Less_Byte-1:0]          hdr_user,
    output logic                          err_valid,
    output logic [1:0]                    err_code
);

    noc_depkt_state_t r_state, w_next_state;

    logic                   r_alive;
    logic [Axi_LEN_Bit-1:0] r_cnt;
    logic                   r_err_valid;
    logic [1:0]             r_err_code;

    noc_head_flit_t w_head;
    logic           w_head_ok, w_dest_ok, w_tail_ok;
    logic           w_in_ready, w_fire, w_pipe_in_ready;
    logic           w_beat_load, w_last, w_cnt_dec;
    logic           w_hdr_load, w_hdr_clr, w_err_set;
    logic [1:0]     w_err_code;
    logic [Noc_Data_Width:0] w_pipe_out;

    assign w_head    = noc_head_flit_t'(in_flit);
    assign w_head_ok = (w_head.head_h == Noc_Head_H) && (w_head.head_e == Noc_Head_E);
    assign w_dest_ok = (w_head.dst_x == MY_X) && (w_head.dst_y == MY_Y);
    assign w_tail_ok = (in_flit[127:124] == Noc_Tail_H) && (in_flit[3:0] == Noc_Tail_E);

    // Only DATA waits on the output register; the other states always consume.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = r_alive;
            DATA:    w_in_ready = w_pipe_in_ready;
            TAIL:    w_in_ready = 1'b1;
            DROP:    w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign in_ready = w_in_ready;
    assign w_fire   = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_beat_load  = 1'b0;
        w_last       = 1'b0;
        w_cnt_dec    = 1'b0;
        w_hdr_load   = 1'b0;
        w_hdr_clr    = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = ERR_HEAD;
        case (r_state)
            IDLE: if (w_fire) begin
                if (!w_head_ok) begin
                    w_err_set = 1'b1;
                end else if (!w_dest_ok) begin
                    w_err_set    = 1'b1;
                    w_err_code   = ERR_DEST;
                    w_next_state = DROP;
                end else begin
                    w_hdr_load   = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA: if (w_fire) begin
                w_beat_load = 1'b1;
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_next_state = TAIL;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            TAIL: if (w_fire) begin
                w_hdr_clr = 1'b1;
                if (w_tail_ok) begin
                    w_next_state = IDLE;
                end else begin
                    w_err_set    = 1'b1;
                    w_err_code   = ERR_TAIL;
                    w_next_state = DROP;
                end
            end
            DROP: if (w_fire && w_tail_ok) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive     <= 1'b0;
            r_cnt       <= '0;
            hdr_valid   <= 1'b0;
            hdr_src_x   <= '0;
            hdr_src_y   <= '0;
            hdr_type    <= '0;
            hdr_order   <= '0;
            hdr_len     <= '0;
            hdr_user    <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_alive     <= 1'b1;
            r_err_valid <= w_err_set;
            if (w_err_set) r_err_code <= w_err_code;
            if (w_hdr_load) begin
                hdr_valid <= 1'b1;
                hdr_src_x <= w_head.src_x;
                hdr_src_y <= w_head.src_y;
                hdr_type  <= w_head.typ;
                hdr_order <= w_head.order;
                hdr_len   <= w_head.len;
                hdr_user  <= w_head.user;
                r_cnt     <= w_head.len;
            end else begin
                if (w_hdr_clr) hdr_valid <= 1'b0;
                if (w_cnt_dec) r_cnt <= r_cnt - Axi_LEN_Bit'(1);
            end
        end
    end

    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;

    noc_pipe_reg #(
        .WIDTH(Noc_Data_Width + 1)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_beat_load),
        .in_ready (w_pipe_in_ready),
        .in_data  ({w_last, in_flit}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_pipe_out)
    );

    assign out_last = w_pipe_out[Noc_Data_Width];
    assign out_data = w_pipe_out[Noc_Data_Width-1:0];

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// tb/tb_noc_flit_depacketizer.sv - directed packets checked against a packet-level model of the depacketizer
module tb_noc_flit_depacketizer;
    import noc_flit_depacketizer_pkg::*;

    typedef logic [127:0] flit_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    flit_t       in_flit;
    logic        out_valid;
    logic        out_ready;
    flit_t       out_data;
    logic        out_last;
    logic        hdr_valid;
    logic [1:0]  hdr_src_x;
    logic [1:0]  hdr_src_y;
    logic [2:0]  hdr_type;
    logic [7:0]  hdr_order;
    logic [7:0]  hdr_len;
    logic [92:0] hdr_user;
    logic        err_valid;
    logic [1:0]  err_code;

    noc_flit_depacketizer #(.MY_X(2'd0), .MY_Y(2'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .hdr_valid(hdr_valid), .hdr_src_x(hdr_src_x), .hdr_src_y(hdr_src_y),
        .hdr_type(hdr_type), .hdr_order(hdr_order), .hdr_len(hdr_len), .hdr_user(hdr_user),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     nbeats = 0;
    int     last_beat_cyc = 0;
    bit     tput_chk = 0;
    bit     data_phase = 0;
    bit     toggle = 0;
    bit     stall_prev = 0;
    logic [128:0] stall_val;
    logic [128:0] beat_q[$];
    logic [1:0]   err_q[$];
    flit_t        cur_pkt[$];
    localparam logic [92:0] USER = 93'h0ABCDE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk_head(input logic [3:0] hh, input logic [1:0] sx, input logic [1:0] sy,
                                      input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] ty,
                                      input logic [7:0] od, input logic [7:0] ln);
        return {hh, sx, sy, dx, dy, ty, od, ln, Noc_Head_E, USER};
    endfunction

    function automatic flit_t mk_data(input int k);
        return {24'hDA7A00, 8'(k), 88'h0, 8'(k)};
    endfunction

    function automatic flit_t mk_tail();
        return {Noc_Tail_H, 120'hF00D, Noc_Tail_E};
    endfunction

    task automatic build_pkt(input flit_t head, input int ndata, input int base);
        cur_pkt.delete();
        cur_pkt.push_back(head);
        for (int i = 0; i < ndata; i++) cur_pkt.push_back(mk_data(base + i));
        cur_pkt.push_back(mk_tail());
    endtask

    // Packet-level view: a good head yields len+1 beats, then the next flit must be a tail.
    task automatic model_packet(output bit good, output int n);
        flit_t h, t;
        h = cur_pkt[0];
        good = 0;
        n = 0;
        if (h[127:124] != Noc_Head_H || h[96:93] != Noc_Head_E) begin
            err_q.push_back(2'd1);
        end else if (h[119:118] != 2'd0 || h[117:116] != 2'd0) begin
            err_q.push_back(2'd2);
        end else begin
            good = 1;
            n = int'(h[104:97]) + 1;
            for (int i = 0; i < n; i++)
                if (1 + i < cur_pkt.size()) beat_q.push_back({(i == n - 1), cur_pkt[1 + i]});
            if (n + 1 < cur_pkt.size()) begin
                t = cur_pkt[n + 1];
                if (!(t[127:124] == Noc_Tail_H && t[3:0] == Noc_Tail_E)) err_q.push_back(2'd3);
            end
        end
    endtask

    task automatic send_flit(input flit_t f);
        bit acc = 0;
        int k = 0;
        in_valid = 1'b1;
        in_flit  = f;
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: accepted=%0d required=1", acc);
        end
    endtask

    task automatic run_pkt();
        bit good;
        int n;
        model_packet(good, n);
        for (int i = 0; i < cur_pkt.size(); i++) begin
            data_phase = good && i >= 1 && i <= n;
            send_flit(cur_pkt[i]);
            if (good && i == 0) chk("hdr_valid_after_head", hdr_valid, 1);
        end
        data_phase = 0;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_check();
        wait_cycles(8);
        chk("beats_outstanding", beat_q.size(), 0);
        chk("errors_outstanding", err_q.size(), 0);
    endtask

    initial begin
        int pidx = 0;
        logic [3:0] pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle) begin
                out_ready = pat[3 - (pidx % 4)];
                pidx++;
            end else begin
                out_ready = 1'b1;
                pidx = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_beat_held", {out_last, out_data}, stall_val);
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_last, out_data};
            if (data_phase && out_valid && !out_ready) chk("in_ready_when_full", in_ready, 0);
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    chk("beat", {out_last, out_data}, beat_q.pop_front());
                    if (tput_chk && nbeats > 0) chk("throughput", cyc - last_beat_cyc, 1);
                end
                nbeats++;
                last_beat_cyc = cyc;
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_err: got %0d expected none", err_code);
                end else begin
                    chk("err_code_pulse", err_code, err_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_flit  = '0;
        wait_cycles(2);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_hdr_fields", {hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len, hdr_user}, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", in_ready, 1);

        // basic packet, out_ready held high
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd1, 2'd0, 2'd0, 3'd3, 8'd5, 8'd3), 4, 0);
        nbeats = 0;
        tput_chk = 1;
        run_pkt();
        drain_check();
        tput_chk = 0;
        chk("t1_beats", nbeats, 4);
        chk("t1_hdr_len", hdr_len, 3);
        chk("t1_hdr_src", {hdr_src_x, hdr_src_y}, 4'b1001);
        chk("t1_hdr_type", hdr_type, 3);
        chk("t1_hdr_order", hdr_order, 5);
        chk("t1_hdr_user", hdr_user, USER);
        chk("t1_hdr_valid_after_tail", hdr_valid, 0);
        chk("t1_no_err", err_code, 0);

        // same packet with backpressure
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd1, 2'd0, 2'd0, 3'd3, 8'd5, 8'd3), 4, 16);
        nbeats = 0;
        toggle = 1;
        run_pkt();
        drain_check();
        toggle = 0;
        chk("t2_beats", nbeats, 4);

        // misrouted packet then a good one
        build_pkt(mk_head(Noc_Head_H, 2'd3, 2'd2, 2'd1, 2'd1, 3'd1, 8'd9, 8'd1), 2, 32);
        nbeats = 0;
        run_pkt();
        drain_check();
        chk("t3_beats", nbeats, 0);
        chk("t3_err_code", err_code, 2);
        build_pkt(mk_head(Noc_Head_H, 2'd1, 2'd3, 2'd0, 2'd0, 3'd2, 8'd7, 8'd3), 4, 40);
        run_pkt();
        drain_check();
        chk("t3_good_beats", nbeats, 4);
        chk("t3_good_hdr_src", {hdr_src_x, hdr_src_y}, 4'b0111);

        // bad head marker
        cur_pkt.delete();
        cur_pkt.push_back(mk_head(4'hB, 2'd2, 2'd1, 2'd0, 2'd0, 3'd3, 8'd5, 8'd3));
        nbeats = 0;
        run_pkt();
        drain_check();
        chk("t4_beats", nbeats, 0);
        chk("t4_err_code", err_code, 1);

        // len=1 with one data flit too many
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0, 8'd1, 8'd1), 3, 64);
        nbeats = 0;
        run_pkt();
        drain_check();
        chk("t5_beats", nbeats, 2);
        chk("t5_err_code", err_code, 3);
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd1, 2'd0, 2'd0, 3'd3, 8'd5, 8'd3), 4, 80);
        nbeats = 0;
        run_pkt();
        drain_check();
        chk("t5_recover_beats", nbeats, 4);

        // asynchronous reset in the middle of DATA
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd1, 2'd0, 2'd0, 3'd3, 8'd5, 8'd3), 4, 96);
        begin
            bit good;
            int n;
            model_packet(good, n);
        end
        send_flit(cur_pkt[0]);
        data_phase = 1;
        send_flit(cur_pkt[1]);
        send_flit(cur_pkt[2]);
        data_phase = 0;
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        beat_q.delete();
        err_q.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_hdr_valid", hdr_valid, 0);
        chk("arst_hdr_len", hdr_len, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_err_code", err_code, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(1);
        build_pkt(mk_head(Noc_Head_H, 2'd2, 2'd1, 2'd0, 2'd0, 3'd4, 8'd6, 8'd3), 4, 112);
        nbeats = 0;
        run_pkt();
        drain_check();
        chk("t6_beats", nbeats, 4);
        chk("t6_hdr_type", hdr_type, 4);
        chk("t6_hdr_order", hdr_order, 6);
        chk("t6_no_err", err_code, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
